// File: rtl/mac_pkg.sv
// Shared constants for the mac_spst_tiny multiply-accumulate block.
package mac_pkg;
  localparam int WIDTH = 8;          // operand width
  localparam int ACC_W = 2 * WIDTH;  // accumulator / product width
endpackage

// File: rtl/array_mult.sv
// Unsigned WIDTH x WIDTH combinational array multiplier.
// Partial-product rows are folded into a sum/carry pair with 3:2 compressors,
// then a ripple-carry adder resolves the final product.
module array_mult #(
  parameter int WIDTH = mac_pkg::WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);
  localparam int AW = 2 * WIDTH;

  logic [AW-1:0] w_s, w_c, w_pp, w_ns, w_nc;
  logic          w_cy;

  // Carry-save reduction of the partial-product rows, then final ripple add.
  always_comb begin
    w_s  = '0;
    w_c  = '0;
    w_pp = '0;
    w_ns = '0;
    w_nc = '0;
    w_cy = 1'b0;
    p    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pp = AW'(a & {WIDTH{b[i]}}) << i;
      w_ns = w_s ^ w_c ^ w_pp;
      // Carries out of the top bit are dropped; the product always fits in AW.
      w_nc = ((w_s & w_c) | (w_s & w_pp) | (w_c & w_pp)) << 1;
      w_s  = w_ns;
      w_c  = w_nc;
    end
    for (int j = 0; j < AW; j++) begin
      p[j] = w_s[j] ^ w_c[j] ^ w_cy;
      w_cy = (w_s[j] & w_c[j]) | (w_cy & (w_s[j] ^ w_c[j]));
    end
  end
endmodule

// File: rtl/mac_spst_tiny.sv
// Multiply-accumulate with tri-state upper-half bus and external preload.
// Optional macro SPST_GATE_EN: zero the multiplier operands while acc_en=0
// so the array does not toggle when idle (results are unchanged).
module mac_spst_tiny #(
  parameter int WIDTH = mac_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc_en,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] out_low,
  inout  wire  [WIDTH-1:0] io_high,
  input  logic             io_drive,
  input  logic             load_ext_high
);
  localparam int AW = 2 * WIDTH;

  logic [AW-1:0]    r_acc;
  logic [WIDTH-1:0] w_mul_a, w_mul_b;
  logic [AW-1:0]    w_prod;

`ifdef SPST_GATE_EN
  assign w_mul_a = in_a & {WIDTH{acc_en}};
  assign w_mul_b = in_b & {WIDTH{acc_en}};
`else
  assign w_mul_a = in_a;
  assign w_mul_b = in_b;
`endif

  array_mult #(.WIDTH(WIDTH)) u_mult (
    .a (w_mul_a),
    .b (w_mul_b),
    .p (w_prod)
  );

  // Accumulator: reset, then pin preload of the upper half, then accumulate.
  always_ff @(posedge clk) begin
    if (rst)
      r_acc <= '0;
    else if (load_ext_high)
      r_acc[AW-1:WIDTH] <= io_high;  // pin value, whoever drives it
    else if (acc_en)
      r_acc <= r_acc + w_prod;       // wraps modulo 2^AW
  end

  assign out_low = r_acc[WIDTH-1:0];
  assign io_high = io_drive ? r_acc[AW-1:WIDTH] : {WIDTH{1'bz}};
endmodule

// File: tb/tb_mac_spst_tiny.sv
// Self-checking bench for mac_spst_tiny: vector table plus a randomized
// accumulate run, both feeding an expected-value queue.
module tb_mac_spst_tiny;
  logic       clk = 1'b0;
  logic       rst, acc_en, io_drive, load_ext_high;
  logic [7:0] in_a, in_b, out_low;
  wire  [7:0] io_bus;
  logic       tb_en;
  logic [7:0] tb_drv;

  int total = 0;
  int bad   = 0;

  assign io_bus = tb_en ? tb_drv : 8'bzzzzzzzz;

  mac_spst_tiny #(.WIDTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .acc_en        (acc_en),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_low       (out_low),
    .io_high       (io_bus),
    .io_drive      (io_drive),
    .load_ext_high (load_ext_high)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, en, ld, drv;
    logic [7:0]  a, b;
    logic        pe;
    logic [7:0]  pin;
    logic [15:0] acc;
  } vec_t;

  typedef struct {
    logic [15:0] acc;
    logic        pe;
    logic [7:0]  pin;
    int          id;
  } exp_t;

  exp_t q[$];
  vec_t tbl[22];

  task automatic check_one();
    exp_t       e;
    logic [7:0] hi;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL queue_empty: no expected entry available");
      return;
    end
    e = q.pop_front();
    total++;
    if (out_low !== e.acc[7:0]) begin
      bad++;
      $display("FAIL out_low[%0d]: got %h want %h", e.id, out_low, e.acc[7:0]);
    end
    // When the bench drives the pin, the DUT must be released, so the bench value shows.
    hi = e.pe ? e.pin : e.acc[15:8];
    total++;
    if (io_bus !== hi) begin
      bad++;
      $display("FAIL io_high[%0d]: got %h want %h", e.id, io_bus, hi);
    end
  endtask

  task automatic step(input vec_t v, input int id);
    exp_t e;
    rst = v.rst; acc_en = v.en; load_ext_high = v.ld; io_drive = v.drv;
    in_a = v.a; in_b = v.b; tb_en = v.pe; tb_drv = v.pin;
    e.acc = v.acc; e.pe = v.pe; e.pin = v.pin; e.id = id;
    q.push_back(e);
    @(posedge clk);
    #1;
    check_one();
  endtask

  initial begin
    vec_t        v;
    logic [15:0] m;
    rst = 1'b1; acc_en = 1'b0; load_ext_high = 1'b0; io_drive = 1'b1;
    in_a = '0; in_b = '0; tb_en = 1'b0; tb_drv = '0;

    //           rst en ld drv  a      b      pe pin    acc
    // reset with everything else active
    tbl[0]  = '{1, 1, 0, 1, 8'hFF, 8'hFF, 0, 8'h00, 16'h0000};
    tbl[1]  = '{1, 1, 0, 1, 8'hFF, 8'hFF, 0, 8'h00, 16'h0000};
    // accumulate 12 + 10 + 200 = 0xDE, then idle
    tbl[2]  = '{0, 1, 0, 1, 8'd3,   8'd4,  0, 8'h00, 16'h000C};
    tbl[3]  = '{0, 1, 0, 1, 8'd2,   8'd5,  0, 8'h00, 16'h0016};
    tbl[4]  = '{0, 1, 0, 1, 8'd100, 8'd2,  0, 8'h00, 16'h00DE};
    tbl[5]  = '{0, 0, 0, 1, 8'h77,  8'h99, 0, 8'h00, 16'h00DE};
    tbl[6]  = '{0, 0, 0, 1, 8'h77,  8'h99, 0, 8'h00, 16'h00DE};
    // external preload of 0xAA while DUT released the bus
    tbl[7]  = '{0, 0, 1, 0, 8'h00,  8'h00, 1, 8'hAA, 16'hAADE};
    tbl[8]  = '{0, 0, 0, 1, 8'h00,  8'h00, 0, 8'h00, 16'hAADE};
    // wrap: 0xFE01 twice -> 0x1FC02 -> 0xFC02
    tbl[9]  = '{1, 0, 0, 1, 8'h00,  8'h00, 0, 8'h00, 16'h0000};
    tbl[10] = '{0, 1, 0, 1, 8'hFF,  8'hFF, 0, 8'h00, 16'hFE01};
    tbl[11] = '{0, 1, 0, 1, 8'hFF,  8'hFF, 0, 8'h00, 16'hFC02};
    // load and accumulate together: load wins, product 4 dropped
    tbl[12] = '{1, 0, 0, 1, 8'h00,  8'h00, 0, 8'h00, 16'h0000};
    tbl[13] = '{0, 1, 0, 1, 8'd1,   8'd5,  0, 8'h00, 16'h0005};
    tbl[14] = '{0, 1, 1, 0, 8'd2,   8'd2,  1, 8'h11, 16'h1105};
    tbl[15] = '{0, 0, 0, 1, 8'd2,   8'd2,  0, 8'h00, 16'h1105};
    // load while DUT drives its own value back: no change
    tbl[16] = '{0, 0, 1, 1, 8'd0,   8'd0,  0, 8'h00, 16'h1105};
    // reset in the middle of accumulation, then restart from zero
    tbl[17] = '{0, 1, 0, 1, 8'd3,   8'd4,  0, 8'h00, 16'h1111};
    tbl[18] = '{1, 1, 0, 1, 8'd3,   8'd4,  0, 8'h00, 16'h0000};
    tbl[19] = '{0, 1, 0, 1, 8'd3,   8'd4,  0, 8'h00, 16'h000C};
    tbl[20] = '{0, 1, 0, 1, 8'h80,  8'h80, 0, 8'h00, 16'h400C};
    tbl[21] = '{0, 0, 0, 1, 8'h5A,  8'hC3, 0, 8'h00, 16'h400C};

    for (int i = 0; i < 22; i++) step(tbl[i], i);

    // Randomized accumulate run against a plain arithmetic model.
    v = '{1, 0, 0, 1, 8'h00, 8'h00, 0, 8'h00, 16'h0000};
    step(v, 100);
    m = 16'h0000;
    for (int k = 0; k < 40; k++) begin
      v.rst = 0; v.ld = 0; v.drv = 1; v.pe = 0; v.pin = 8'h00;
      v.en  = 1'($urandom_range(0, 3) != 0);
      v.a   = 8'($urandom_range(0, 255));
      v.b   = 8'($urandom_range(0, 255));
      if (v.en) m = m + 16'(v.a) * 16'(v.b);
      v.acc = m;
      step(v, 200 + k);
    end

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d left want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
